// File: rtl/multicycle_control_unit_pkg.sv
// Shared encodings for the multi-cycle controller: opcodes, FSM states,
// ALU operation codes and PC source selects.
package multicycle_control_unit_pkg;

   localparam int unsigned OPW_DEF    = 6;
   localparam int unsigned ALUOPW_DEF = 3;

   localparam logic [5:0] OP_ADD   = 6'b000000;
   localparam logic [5:0] OP_SUB   = 6'b000001;
   localparam logic [5:0] OP_ADDIU = 6'b000010;
   localparam logic [5:0] OP_AND   = 6'b010000;
   localparam logic [5:0] OP_ANDI  = 6'b010001;
   localparam logic [5:0] OP_ORI   = 6'b010010;
   localparam logic [5:0] OP_SLT   = 6'b100110;
   localparam logic [5:0] OP_SLTI  = 6'b100111;
   localparam logic [5:0] OP_SW    = 6'b110000;
   localparam logic [5:0] OP_LW    = 6'b110001;
   localparam logic [5:0] OP_BEQ   = 6'b110100;
   localparam logic [5:0] OP_BNE   = 6'b110101;
   localparam logic [5:0] OP_J     = 6'b111000;
   localparam logic [5:0] OP_HALT  = 6'b111111;

   typedef enum logic [3:0] {
      S_IF     = 4'b0000,
      S_ID     = 4'b0001,
      S_EXE_AL = 4'b0010,
      S_WB_AL  = 4'b0011,
      S_EXE_LS = 4'b0100,
      S_MEM    = 4'b0101,
      S_WB_LD  = 4'b0110,
      S_EXE_BR = 4'b0111,
      S_HALT   = 4'b1000
   } stateT;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_SLT = 3'b010;
   localparam logic [2:0] ALU_AND = 3'b100;
   localparam logic [2:0] ALU_OR  = 3'b101;

   localparam logic [1:0] PC_NEXT   = 2'b00;
   localparam logic [1:0] PC_BRANCH = 2'b01;
   localparam logic [1:0] PC_JUMP   = 2'b10;

   // True for opcodes that take the EXE_AL/WB_AL path
   function automatic logic isAluOp(input logic [5:0] op);
      case (op)
         OP_ADD, OP_SUB, OP_ADDIU, OP_AND, OP_ANDI,
         OP_ORI, OP_SLT, OP_SLTI:  return 1'b1;
         default:                  return 1'b0;
      endcase
   endfunction

   // True for every opcode the controller recognises
   function automatic logic isKnownOp(input logic [5:0] op);
      case (op)
         OP_SW, OP_LW, OP_BEQ, OP_BNE, OP_J, OP_HALT: return 1'b1;
         default:                                     return isAluOp(op);
      endcase
   endfunction

endpackage

// File: rtl/multicycle_control_unit_output_decode.sv
// Combinational decode of (state, opcode, zero) into every datapath
// select and write enable.
module mc_output_decode
   import multicycle_control_unit_pkg::*;
#(
   parameter int unsigned OPW    = OPW_DEF,
   parameter int unsigned ALUOPW = ALUOPW_DEF
) (
   input  stateT             state,
   input  logic [OPW-1:0]    Opcode,
   input  logic              Zero,
   output logic              PCWre,
   output logic              IRWre,
   output logic              InsMemRW,
   output logic              ExtSel,
   output logic              ALUSrcB,
   output logic [ALUOPW-1:0] ALUOp,
   output logic              RegDst,
   output logic              RegWre,
   output logic              DBDataSrc,
   output logic              mRD,
   output logic              mWR,
   output logic [1:0]        PCSrc,
   output logic              Halted
);

   // Per-state control decode; everything defaults to 0
   always_comb begin
      PCWre     = 1'b0;
      IRWre     = 1'b0;
      InsMemRW  = 1'b0;
      ExtSel    = 1'b0;
      ALUSrcB   = 1'b0;
      ALUOp     = ALU_ADD;
      RegDst    = 1'b0;
      RegWre    = 1'b0;
      DBDataSrc = 1'b0;
      mRD       = 1'b0;
      mWR       = 1'b0;
      PCSrc     = PC_NEXT;
      Halted    = 1'b0;
      case (state)
         S_IF: begin
            IRWre    = 1'b1;
            InsMemRW = 1'b1;
         end
         S_ID: begin
            if (Opcode == OP_J) begin
               PCWre = 1'b1;
               PCSrc = PC_JUMP;
            end else if (!isKnownOp(Opcode)) begin
               PCWre = 1'b1;
               PCSrc = PC_NEXT;
            end
         end
         S_EXE_AL, S_WB_AL: begin
            case (Opcode)
               OP_ADD:   begin ALUOp = ALU_ADD; RegDst = 1'b1; end
               OP_SUB:   begin ALUOp = ALU_SUB; RegDst = 1'b1; end
               OP_AND:   begin ALUOp = ALU_AND; RegDst = 1'b1; end
               OP_SLT:   begin ALUOp = ALU_SLT; RegDst = 1'b1; end
               OP_ADDIU: begin ALUOp = ALU_ADD; ALUSrcB = 1'b1; ExtSel = 1'b1; end
               OP_SLTI:  begin ALUOp = ALU_SLT; ALUSrcB = 1'b1; ExtSel = 1'b1; end
               OP_ANDI:  begin ALUOp = ALU_AND; ALUSrcB = 1'b1; end
               OP_ORI:   begin ALUOp = ALU_OR;  ALUSrcB = 1'b1; end
               default:  ;
            endcase
            if (state == S_WB_AL) begin
               RegWre = 1'b1;
               PCWre  = 1'b1;
            end
         end
         S_EXE_LS, S_MEM, S_WB_LD: begin
            ALUSrcB = 1'b1;
            ALUOp   = ALU_ADD;
            ExtSel  = 1'b1;
            if (state == S_MEM) begin
               if (Opcode == OP_SW) begin
                  mWR   = 1'b1;
                  PCWre = 1'b1;
               end else begin
                  mRD = 1'b1;
               end
            end else if (state == S_WB_LD) begin
               mRD       = 1'b1;
               DBDataSrc = 1'b1;
               RegWre    = 1'b1;
               PCWre     = 1'b1;
            end
         end
         S_EXE_BR: begin
            ALUOp  = ALU_SUB;
            ExtSel = 1'b1;
            PCWre  = 1'b1;
            if ((Opcode == OP_BEQ && Zero) || (Opcode == OP_BNE && !Zero))
               PCSrc = PC_BRANCH;
         end
         S_HALT: Halted = 1'b1;
         default: ;
      endcase
   end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multi-cycle controller top: state register and next-state logic; the
// control outputs come from mc_output_decode.
module multicycle_control_unit
   import multicycle_control_unit_pkg::*;
#(
   parameter int unsigned OPW    = OPW_DEF,
   parameter int unsigned ALUOPW = ALUOPW_DEF
) (
   input  logic              CLK,
   input  logic              Reset,
   input  logic [OPW-1:0]    Opcode,
   input  logic              Zero,
   output logic              PCWre,
   output logic              IRWre,
   output logic              InsMemRW,
   output logic              ExtSel,
   output logic              ALUSrcB,
   output logic [ALUOPW-1:0] ALUOp,
   output logic              RegDst,
   output logic              RegWre,
   output logic              DBDataSrc,
   output logic              mRD,
   output logic              mWR,
   output logic [1:0]        PCSrc,
   output logic [3:0]        State,
   output logic              Halted
);

   stateT stateReg;
   stateT stateNext;

   // State register; reset overrides any pending transition, HALT included
   always_ff @(posedge CLK) begin
      if (Reset) stateReg <= S_IF;
      else       stateReg <= stateNext;
   end

   // Next-state sequencing through the instruction phases
   always_comb begin
      stateNext = S_IF;
      case (stateReg)
         S_IF: stateNext = S_ID;
         S_ID: begin
            if (isAluOp(Opcode))                          stateNext = S_EXE_AL;
            else if (Opcode == OP_LW || Opcode == OP_SW)  stateNext = S_EXE_LS;
            else if (Opcode == OP_BEQ || Opcode == OP_BNE) stateNext = S_EXE_BR;
            else if (Opcode == OP_HALT)                   stateNext = S_HALT;
            else                                          stateNext = S_IF;
         end
         S_EXE_AL: stateNext = S_WB_AL;
         S_WB_AL:  stateNext = S_IF;
         S_EXE_LS: stateNext = S_MEM;
         S_MEM:    stateNext = (Opcode == OP_LW) ? S_WB_LD : S_IF;
         S_WB_LD:  stateNext = S_IF;
         S_EXE_BR: stateNext = S_IF;
         S_HALT:   stateNext = S_HALT;
         default:  stateNext = S_IF;
      endcase
   end

   assign State = stateReg;

   mc_output_decode #(
      .OPW    (OPW),
      .ALUOPW (ALUOPW)
   ) uDecode (
      .state     (stateReg),
      .Opcode    (Opcode),
      .Zero      (Zero),
      .PCWre     (PCWre),
      .IRWre     (IRWre),
      .InsMemRW  (InsMemRW),
      .ExtSel    (ExtSel),
      .ALUSrcB   (ALUSrcB),
      .ALUOp     (ALUOp),
      .RegDst    (RegDst),
      .RegWre    (RegWre),
      .DBDataSrc (DBDataSrc),
      .mRD       (mRD),
      .mWR       (mWR),
      .PCSrc     (PCSrc),
      .Halted    (Halted)
   );

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed bench for multicycle_control_unit: walks each instruction class
// cycle by cycle against hand-computed state and control vectors.
module tb_multicycle_control_unit;

   logic       CLK = 1'b0;
   logic       Reset;
   logic [5:0] Opcode;
   logic       Zero;
   logic       PCWre, IRWre, InsMemRW, ExtSel, ALUSrcB, RegDst, RegWre;
   logic       DBDataSrc, mRD, mWR, Halted;
   logic [2:0] ALUOp;
   logic [1:0] PCSrc;
   logic [3:0] State;

   int checks   = 0;
   int failures = 0;

   multicycle_control_unit #(.OPW(6), .ALUOPW(3)) dut (
      .CLK(CLK), .Reset(Reset), .Opcode(Opcode), .Zero(Zero),
      .PCWre(PCWre), .IRWre(IRWre), .InsMemRW(InsMemRW), .ExtSel(ExtSel),
      .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .RegDst(RegDst), .RegWre(RegWre),
      .DBDataSrc(DBDataSrc), .mRD(mRD), .mWR(mWR), .PCSrc(PCSrc),
      .State(State), .Halted(Halted)
   );

   always #5 CLK = ~CLK;

   // Control vector layout: P I M E B AAA D W S R X CC H
   //   PCWre IRWre InsMemRW ExtSel ALUSrcB ALUOp RegDst RegWre
   //   DBDataSrc mRD mWR PCSrc Halted
   logic [16:0] ctrl;
   assign ctrl = {PCWre, IRWre, InsMemRW, ExtSel, ALUSrcB, ALUOp, RegDst,
                  RegWre, DBDataSrc, mRD, mWR, PCSrc, Halted};

   localparam logic [16:0] C_IF     = 17'b0_1_1_0_0_000_0_0_0_0_0_00_0;
   localparam logic [16:0] C_ZERO   = 17'b0_0_0_0_0_000_0_0_0_0_0_00_0;
   localparam logic [16:0] C_ADDIUE = 17'b0_0_0_1_1_000_0_0_0_0_0_00_0;
   localparam logic [16:0] C_ADDIUW = 17'b1_0_0_1_1_000_0_1_0_0_0_00_0;
   localparam logic [16:0] C_ORIE   = 17'b0_0_0_0_1_101_0_0_0_0_0_00_0;
   localparam logic [16:0] C_ORIW   = 17'b1_0_0_0_1_101_0_1_0_0_0_00_0;
   localparam logic [16:0] C_SLTE   = 17'b0_0_0_0_0_010_1_0_0_0_0_00_0;
   localparam logic [16:0] C_SLTW   = 17'b1_0_0_0_0_010_1_1_0_0_0_00_0;
   localparam logic [16:0] C_LSE    = 17'b0_0_0_1_1_000_0_0_0_0_0_00_0;
   localparam logic [16:0] C_LWMEM  = 17'b0_0_0_1_1_000_0_0_0_1_0_00_0;
   localparam logic [16:0] C_LWWB   = 17'b1_0_0_1_1_000_0_1_1_1_0_00_0;
   localparam logic [16:0] C_SWMEM  = 17'b1_0_0_1_1_000_0_0_0_0_1_00_0;
   localparam logic [16:0] C_BRTAK  = 17'b1_0_0_1_0_001_0_0_0_0_0_01_0;
   localparam logic [16:0] C_BRNOT  = 17'b1_0_0_1_0_001_0_0_0_0_0_00_0;
   localparam logic [16:0] C_JID    = 17'b1_0_0_0_0_000_0_0_0_0_0_10_0;
   localparam logic [16:0] C_NOPID  = 17'b1_0_0_0_0_000_0_0_0_0_0_00_0;
   localparam logic [16:0] C_HALT   = 17'b0_0_0_0_0_000_0_0_0_0_0_00_1;

   task automatic checkVal(input string tag, input logic [31:0] got,
                           input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   // Check the current cycle's state and controls, then advance one edge
   task automatic expectCycle(input string tag, input logic [3:0] st,
                              input logic [16:0] c);
      checkVal({tag, ".state"}, {28'd0, State}, {28'd0, st});
      checkVal({tag, ".ctrl"},  {15'd0, ctrl},  {15'd0, c});
      tick();
   endtask

   initial begin
      Reset  = 1'b1;
      Opcode = 6'b000010;
      Zero   = 1'b0;
      tick();
      tick();
      checkVal("reset.state", {28'd0, State}, 32'd0);
      checkVal("reset.ctrl",  {15'd0, ctrl},  {15'd0, C_IF});
      Reset = 1'b0;

      // addiu
      expectCycle("addiu.if",  4'd0, C_IF);
      expectCycle("addiu.id",  4'd1, C_ZERO);
      expectCycle("addiu.exe", 4'd2, C_ADDIUE);
      expectCycle("addiu.wb",  4'd3, C_ADDIUW);

      // ori: zero-extended immediate
      Opcode = 6'b010010;
      expectCycle("ori.if",  4'd0, C_IF);
      expectCycle("ori.id",  4'd1, C_ZERO);
      expectCycle("ori.exe", 4'd2, C_ORIE);
      expectCycle("ori.wb",  4'd3, C_ORIW);

      // slt: R-type with rd destination
      Opcode = 6'b100110;
      expectCycle("slt.if",  4'd0, C_IF);
      expectCycle("slt.id",  4'd1, C_ZERO);
      expectCycle("slt.exe", 4'd2, C_SLTE);
      expectCycle("slt.wb",  4'd3, C_SLTW);

      // lw: five cycles
      Opcode = 6'b110001;
      expectCycle("lw.if",  4'd0, C_IF);
      expectCycle("lw.id",  4'd1, C_ZERO);
      expectCycle("lw.exe", 4'd4, C_LSE);
      expectCycle("lw.mem", 4'd5, C_LWMEM);
      expectCycle("lw.wb",  4'd6, C_LWWB);

      // sw: four cycles
      Opcode = 6'b110000;
      expectCycle("sw.if",  4'd0, C_IF);
      expectCycle("sw.id",  4'd1, C_ZERO);
      expectCycle("sw.exe", 4'd4, C_LSE);
      expectCycle("sw.mem", 4'd5, C_SWMEM);

      // beq taken / bne not taken with Zero=1; then the Zero=0 cases
      Zero   = 1'b1;
      Opcode = 6'b110100;
      expectCycle("beqz.if", 4'd0, C_IF);
      expectCycle("beqz.id", 4'd1, C_ZERO);
      expectCycle("beqz.br", 4'd7, C_BRTAK);
      Opcode = 6'b110101;
      expectCycle("bnez.if", 4'd0, C_IF);
      expectCycle("bnez.id", 4'd1, C_ZERO);
      expectCycle("bnez.br", 4'd7, C_BRNOT);
      Zero   = 1'b0;
      Opcode = 6'b110100;
      expectCycle("beqnz.if", 4'd0, C_IF);
      expectCycle("beqnz.id", 4'd1, C_ZERO);
      expectCycle("beqnz.br", 4'd7, C_BRNOT);
      Opcode = 6'b110101;
      expectCycle("bnenz.if", 4'd0, C_IF);
      expectCycle("bnenz.id", 4'd1, C_ZERO);
      expectCycle("bnenz.br", 4'd7, C_BRTAK);

      // j and an undefined opcode: two cycles each
      Opcode = 6'b111000;
      expectCycle("j.if", 4'd0, C_IF);
      expectCycle("j.id", 4'd1, C_JID);
      Opcode = 6'b001111;
      expectCycle("undef.if", 4'd0, C_IF);
      expectCycle("undef.id", 4'd1, C_NOPID);

      // sw interrupted by reset in MEM
      Opcode = 6'b110000;
      expectCycle("swr.if",  4'd0, C_IF);
      expectCycle("swr.id",  4'd1, C_ZERO);
      expectCycle("swr.exe", 4'd4, C_LSE);
      checkVal("swr.mem.state", {28'd0, State}, 32'd5);
      checkVal("swr.mem.mWR",   {31'd0, mWR},   32'd1);
      Reset = 1'b1;
      tick();
      Reset = 1'b0;
      checkVal("swr.rst.state", {28'd0, State}, 32'd0);
      checkVal("swr.rst.ctrl",  {15'd0, ctrl},  {15'd0, C_IF});
      checkVal("swr.rst.wren",  {29'd0, PCWre, RegWre, mWR}, 32'd0);

      // halt: stays put until reset
      Opcode = 6'b111111;
      expectCycle("halt.if", 4'd0, C_IF);
      expectCycle("halt.id", 4'd1, C_ZERO);
      for (int i = 0; i < 11; i++)
         expectCycle($sformatf("halt.c%0d", i), 4'd8, C_HALT);
      Reset = 1'b1;
      tick();
      Reset = 1'b0;
      checkVal("halt.rst.state", {28'd0, State}, 32'd0);
      checkVal("halt.rst.ctrl",  {15'd0, ctrl},  {15'd0, C_IF});

      // addiu again after leaving HALT
      Opcode = 6'b000010;
      expectCycle("post.if",  4'd0, C_IF);
      expectCycle("post.id",  4'd1, C_ZERO);
      expectCycle("post.exe", 4'd2, C_ADDIUE);
      expectCycle("post.wb",  4'd3, C_ADDIUW);
      checkVal("post.done.state", {28'd0, State}, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/multicycle_control_unit.md
Name: multicycle_control_unit

Overview:
- Multi-cycle controller that sequences the CPU datapath (PC, IR, register file, Extend unit, ALU, data memory) through IF/ID/EXE/MEM/WB phases.
- A state register steps each instruction through its phases. The unit decodes the 6-bit opcode held in IR and drives every datapath select and write enable, including ExtSel for the immediate extender.
- It sits beside the datapath top level and replaces the single-cycle combinational decoder.

Parameters:
- OPW, 6, opcode width.
- ALUOPW, 3, ALU operation code width.

Ports:
- CLK  in  1  system clock; all state changes on the rising edge.
- Reset  in  1  synchronous, active-high reset.
- Opcode  in  OPW  opcode field of the IR output, stable from ID onward.
- Zero  in  1  ALU result == 0.
- PCWre  out  1  PC write enable.
- IRWre  out  1  IR load enable.
- InsMemRW  out  1  instruction-memory read enable.
- ExtSel  out  1  1 = sign extend, 0 = zero extend.
- ALUSrcB  out  1  1 = extended immediate, 0 = rt data.
- ALUOp  out  ALUOPW  000 add, 001 sub, 010 slt (signed), 100 and, 101 or.
- RegDst  out  1  1 = rd, 0 = rt.
- RegWre  out  1  register-file write enable.
- DBDataSrc  out  1  1 = memory data, 0 = ALU result.
- mRD  out  1  data-memory read.
- mWR  out  1  data-memory write.
- PCSrc  out  2  00 = PC+4, 01 = branch target, 10 = jump target.
- State  out  4  current state, for debug.
- Halted  out  1  high in HALT.

Behaviour:
- Opcodes:
  - add 000000, sub 000001, addiu 000010
  - and 010000, andi 010001, ori 010010
  - slt 100110, slti 100111
  - sw 110000, lw 110001
  - beq 110100, bne 110101
  - j 111000, halt 111111
- States (4-bit): IF 0000, ID 0001, EXE_AL 0010, WB_AL 0011, EXE_LS 0100, MEM 0101, WB_LD 0110, EXE_BR 0111, HALT 1000.
- Transitions:
  - IF -> ID.
  - ID -> EXE_AL (ALU ops), EXE_LS (lw/sw), EXE_BR (beq/bne), HALT (halt), IF (j or undefined opcode).
  - EXE_AL -> WB_AL -> IF.
  - EXE_LS -> MEM.
  - MEM -> WB_LD (lw), or -> IF (sw).
  - WB_LD -> IF.
  - EXE_BR -> IF.
  - HALT -> HALT.
- Latency in cycles: j and undefined 2, beq/bne 3, ALU ops 4, sw 4, lw 5.
- Outputs are combinational from the state register plus Opcode. Every output is 0 unless listed below.
- IF: IRWre=1, InsMemRW=1.
- ID:
  - j: PCWre=1, PCSrc=10.
  - undefined opcode: PCWre=1, PCSrc=00 (treated as a NOP).
- EXE_AL / WB_AL: ALUSrcB, ALUOp, ExtSel and RegDst per opcode, held stable across both states. WB_AL adds RegWre=1, PCWre=1, PCSrc=00.
- EXE_LS / MEM / WB_LD: ALUSrcB=1, ALUOp=000, ExtSel=1 in all three states.
  - MEM: mWR=1 for sw; mRD=1 for lw. For sw, PCWre=1 in MEM.
  - WB_LD: mRD=1, DBDataSrc=1, RegDst=0, RegWre=1, PCWre=1.
- EXE_BR: ALUOp=001, ExtSel=1, PCWre=1. PCSrc=01 when (beq and Zero) or (bne and not Zero); otherwise 00.
- ExtSel=1 for addiu, slti, lw, sw, beq, bne; ExtSel=0 for andi, ori.
- ALUSrcB=1 for all immediate forms. RegDst=1 only for R-type (add, sub, and, slt).
- HALT: Halted=1, all enables 0. Leaves only on Reset.
- Reset:
  - On a rising edge with Reset=1, State <= IF, overriding any pending transition, including mid-instruction and HALT.
  - Outputs then read as IF values: IRWre=1, InsMemRW=1, rest 0.
  - No write enable (PCWre, RegWre, mWR) may be high in the cycle after a reset edge.
- At most one of PCWre/RegWre/mWR changes architectural state per cycle, except the last cycle of an instruction, where PCWre may coincide with RegWre or mWR.

Decomposition:
- Shared package: opcode localparams, state encodings, ALUOp codes, PCSrc codes.
- One sub-module, mc_output_decode: purely combinational (state, Opcode, Zero) -> control outputs.
- Top level holds only the state register and next-state logic.

Test Plan:
- Reset held 2 cycles, then addiu (000010): State sequence 0,1,2,3,0. ExtSel=1, ALUSrcB=1, RegDst=0. RegWre=1 and PCWre=1 only in cycle 4.
- ori (010010): ExtSel=0 in EXE_AL and WB_AL. lw (110001): 5 cycles, mRD=1 in MEM and WB_LD, DBDataSrc=1 and RegWre=1 only in WB_LD.
- beq with Zero=1 -> PCSrc=01 in EXE_BR. bne with Zero=1 -> PCSrc=00. Both take 3 cycles with PCWre=1 in EXE_BR.
- j (111000): PCSrc=10 and PCWre=1 in ID, back to IF next cycle. Undefined opcode 001111: PCSrc=00, PCWre=1 in ID.
- halt (111111): State=1000, Halted=1 for 10+ cycles, all enables 0. Reset -> State=0 next edge.
- Reset asserted in MEM of sw: mWR never seen high after the reset edge, State=0000.
